// File: rtl/pwm_mem_multi.sv
// Multi-channel PWM block with bus-written shadow registers, committed at period wrap.
// Optional readback port enabled by defining PWM_MEM_READBACK_EN.
module pwm_mem_multi #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 16,
  parameter int PRESC_DIV = 1000,
  parameter int ADDR_W    = 5
) (
  input  logic              sysclk,
  input  logic              i_rst,
  input  logic              i_cs,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [N_CH-1:0]   o_pwm,
  output logic [N_CH-1:0]   o_period_end
`ifdef PWM_MEM_READBACK_EN
  ,
  output logic [7:0]        o_rdata
`endif
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

  logic [PW-1:0]    r_presc;
  logic [N_CH-1:0]  r_ctrl;
  logic [CNT_W-1:0] r_duty_sh  [N_CH];
  logic [CNT_W-1:0] r_per_sh   [N_CH];
  logic [CNT_W-1:0] r_duty_act [N_CH];
  logic [CNT_W-1:0] r_per_act  [N_CH];
  logic [CNT_W-1:0] r_cnt      [N_CH];

  logic              w_tick;
  logic              w_wr;
  logic              w_ch_hit;
  logic              w_ctrl_hit;
  logic [ADDR_W-3:0] w_ch;

  assign w_tick     = (r_presc == PW'(PRESC_DIV - 1));
  assign w_wr       = i_cs & i_we;
  assign w_ch_hit   = (i_addr < ADDR_W'(4 * N_CH));
  assign w_ctrl_hit = (i_addr == ADDR_W'(4 * N_CH));
  assign w_ch       = i_addr[ADDR_W-1:2];

  always_ff @(posedge sysclk) begin
    if (i_rst) begin
      r_presc      <= '0;
      r_ctrl       <= '0;
      o_pwm        <= '0;
      o_period_end <= '0;
      for (int c = 0; c < N_CH; c++) begin
        r_duty_sh[c]  <= '0;
        r_per_sh[c]   <= '0;
        r_duty_act[c] <= '0;
        r_per_act[c]  <= '0;
        r_cnt[c]      <= '0;
      end
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_wr && w_ctrl_hit)
        r_ctrl <= i_wdata[N_CH-1:0];
      for (int c = 0; c < N_CH; c++) begin
        o_period_end[c] <= 1'b0;
        if (w_wr && w_ch_hit && w_ch == (ADDR_W-2)'(c)) begin
          unique case (i_addr[1:0])
            2'd0: r_duty_sh[c][7:0]       <= i_wdata;
            2'd1: r_duty_sh[c][CNT_W-1:8] <= i_wdata[CNT_W-9:0];
            2'd2: r_per_sh[c][7:0]        <= i_wdata;
            2'd3: r_per_sh[c][CNT_W-1:8]  <= i_wdata[CNT_W-9:0];
          endcase
        end
        // Commits read the shadow before any same-cycle write lands
        if (!r_ctrl[c]) begin
          r_cnt[c]      <= '0;
          r_duty_act[c] <= r_duty_sh[c];
          r_per_act[c]  <= r_per_sh[c];
        end else if (w_tick) begin
          if (r_per_act[c] == '0) begin
            r_cnt[c]      <= '0;
            r_duty_act[c] <= r_duty_sh[c];
            r_per_act[c]  <= r_per_sh[c];
          end else if (r_cnt[c] == r_per_act[c] - CNT_W'(1)) begin
            r_cnt[c]        <= '0;
            r_duty_act[c]   <= r_duty_sh[c];
            r_per_act[c]    <= r_per_sh[c];
            o_period_end[c] <= 1'b1;
          end else begin
            r_cnt[c] <= r_cnt[c] + CNT_W'(1);
          end
        end
        o_pwm[c] <= r_ctrl[c] && (r_per_act[c] != '0) &&
                    (r_cnt[c] < r_duty_act[c]);
      end
    end
  end

`ifdef PWM_MEM_READBACK_EN
  logic [7:0] w_rbyte;

  always_comb begin
    w_rbyte = 8'h00;
    if (w_ctrl_hit) begin
      w_rbyte[N_CH-1:0] = r_ctrl;
    end else if (w_ch_hit) begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_ch == (ADDR_W-2)'(c)) begin
          unique case (i_addr[1:0])
            2'd0: w_rbyte             = r_duty_sh[c][7:0];
            2'd1: w_rbyte[CNT_W-9:0]  = r_duty_sh[c][CNT_W-1:8];
            2'd2: w_rbyte             = r_per_sh[c][7:0];
            2'd3: w_rbyte[CNT_W-9:0]  = r_per_sh[c][CNT_W-1:8];
          endcase
        end
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (i_rst)
      o_rdata <= 8'h00;
    else if (i_cs && !i_we)
      o_rdata <= w_rbyte;
  end
`endif

endmodule

// File: tb/tb_pwm_mem_multi.sv
// Scoreboard bench for pwm_mem_multi: per-period and level-window checks.
// Readback checks are compiled when PWM_MEM_READBACK_EN is defined.
module tb_pwm_mem_multi;

  localparam int N  = 4;
  localparam int PD = 4;

  logic       sysclk = 1'b0;
  logic       i_rst;
  logic       i_cs;
  logic       i_we;
  logic [4:0] i_addr;
  logic [7:0] i_wdata;
  logic [N-1:0] o_pwm;
  logic [N-1:0] o_period_end;
`ifdef PWM_MEM_READBACK_EN
  logic [7:0] o_rdata;
`endif

  pwm_mem_multi #(
    .N_CH(N), .CNT_W(16), .PRESC_DIV(PD), .ADDR_W(5)
  ) dut (
    .sysclk(sysclk),
    .i_rst(i_rst),
    .i_cs(i_cs),
    .i_we(i_we),
    .i_addr(i_addr),
    .i_wdata(i_wdata),
    .o_pwm(o_pwm),
`ifdef PWM_MEM_READBACK_EN
    .o_rdata(o_rdata),
`endif
    .o_period_end(o_period_end)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    bit skip;
    int high;
    int len;
  } prec_t;

  typedef struct {
    string    name;
    int       cycles;
    logic [N-1:0] mask;
    logic [N-1:0] exp;
    bit       chk_pe;
  } win_t;

  prec_t pq [N][$];
  win_t  wq [$];
  int    checks = 0;
  int    errors = 0;
  int    hi_cnt [N];
  int    len_cnt[N];
  bit    w_busy = 0;

  // Period monitor: high-cycle count and length between wrap pulses
  initial begin
    for (int c = 0; c < N; c++) begin
      hi_cnt[c]  = 0;
      len_cnt[c] = 0;
    end
    forever begin
      @(negedge sysclk);
      for (int c = 0; c < N; c++) begin
        len_cnt[c]++;
        if (o_pwm[c]) hi_cnt[c]++;
        if (o_period_end[c]) begin
          if (pq[c].size() > 0) begin
            prec_t r;
            r = pq[c].pop_front();
            if (!r.skip) begin
              checks++;
              if (hi_cnt[c] != r.high || len_cnt[c] != r.len) begin
                errors++;
                $display("FAIL period ch%0d: got high=%0d len=%0d, want high=%0d len=%0d",
                         c, hi_cnt[c], len_cnt[c], r.high, r.len);
              end
            end
          end
          hi_cnt[c]  = 0;
          len_cnt[c] = 0;
        end
      end
    end
  end

  // Level-window monitor
  initial begin
    forever begin
      @(negedge sysclk);
      if (wq.size() > 0) begin
        win_t w;
        bit bad;
        logic [N-1:0] gp, gpe;
        w = wq.pop_front();
        w_busy = 1;
        bad = 0;
        gp = '0;
        gpe = '0;
        for (int i = 0; i < w.cycles; i++) begin
          if (i > 0) @(negedge sysclk);
          if (!bad && ((((o_pwm ^ w.exp) & w.mask) != '0) ||
              (w.chk_pe && ((o_period_end & w.mask) != '0)))) begin
            bad = 1;
            gp  = o_pwm;
            gpe = o_period_end;
          end
        end
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL %s: got pwm=%b pe=%b, want pwm=%b (mask %b) pe_quiet=%0d",
                   w.name, gp, gpe, w.exp, w.mask, w.chk_pe);
        end
        w_busy = 0;
      end
    end
  end

`ifdef PWM_MEM_READBACK_EN
  logic [7:0] rq [$];
  bit rd_pend = 0;
  int rd_addr = 0;
  int rq_addr [$];

  always @(negedge sysclk) begin
    if (rd_pend && rq.size() > 0) begin
      logic [7:0] e;
      int a;
      e = rq.pop_front();
      a = rq_addr.pop_front();
      checks++;
      if (o_rdata !== e) begin
        errors++;
        $display("FAIL rdata addr %0d: got %h, want %h", a, o_rdata, e);
      end
    end
    rd_pend = i_cs && !i_we;
  end

  task automatic rd(input logic [4:0] a, input logic [7:0] e);
    rq.push_back(e);
    rq_addr.push_back(int'(a));
    @(posedge sysclk); #1;
    i_cs = 1; i_we = 0; i_addr = a;
    @(posedge sysclk); #1;
    i_cs = 0;
  endtask
`endif

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(posedge sysclk); #1;
    i_cs = 1; i_we = 1; i_addr = a; i_wdata = d;
    @(posedge sysclk); #1;
    i_cs = 0; i_we = 0;
  endtask

  task automatic push_per(input int c, input bit s, input int h, input int l);
    prec_t r;
    r.skip = s;
    r.high = h;
    r.len  = l;
    pq[c].push_back(r);
  endtask

  task automatic push_win(input string nm, input int cyc, input logic [N-1:0] m,
                          input logic [N-1:0] e, input bit cp);
    win_t w;
    w.name = nm;
    w.cycles = cyc;
    w.mask = m;
    w.exp = e;
    w.chk_pe = cp;
    wq.push_back(w);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size()
            + wq.size() != 0 || w_busy) && n < maxc) begin
      @(posedge sysclk);
      n++;
    end
    if (n >= maxc) begin
      checks++;
      errors++;
      $display("FAIL drain: got pending after %0d cycles, want empty", n);
      for (int c = 0; c < N; c++) pq[c].delete();
      wq.delete();
    end
    #1;
  endtask

  task automatic wait_pe(input int c);
    int n = 0;
    @(posedge sysclk);
    do begin
      @(negedge sysclk);
      n++;
    end while (!o_period_end[c] && n < 300);
    if (!o_period_end[c]) begin
      checks++;
      errors++;
      $display("FAIL wait_pe ch%0d: got no pulse in %0d cycles, want pulse", c, n);
    end
    @(posedge sysclk); #1;
  endtask

  initial begin
    i_rst = 1; i_cs = 0; i_we = 0; i_addr = '0; i_wdata = '0;
    repeat (3) @(posedge sysclk);
    #1 i_rst = 0;
    push_win("reset_idle", 20, 4'hF, 4'h0, 1);
    drain(200);

    // ch0 per=10 duty=3
    wr(5'd2, 8'd10); wr(5'd3, 8'd0); wr(5'd0, 8'd3); wr(5'd1, 8'd0);
    wr(5'd16, 8'h01);
    push_per(0, 1, 0, 0);
    push_per(0, 0, 3 * PD, 10 * PD);
    push_per(0, 0, 3 * PD, 10 * PD);
    drain(600);

    // duty change mid-period: current period keeps 3, next shows 7
    wait_pe(0);
    push_per(0, 0, 3 * PD, 10 * PD);
    push_per(0, 0, 7 * PD, 10 * PD);
    repeat (16) @(posedge sysclk);
    #1;
    wr(5'd0, 8'd7);
    drain(600);

    // duty / period edge cases
    wr(5'd0, 8'd0);
    wait_pe(0);
    push_win("duty_zero", 10 * PD, 4'h1, 4'h0, 0);
    drain(200);
    wr(5'd0, 8'd10);
    wait_pe(0);
    push_win("duty_eq_per", 10 * PD, 4'h1, 4'h1, 0);
    drain(200);
    wr(5'd0, 8'hFF); wr(5'd1, 8'hFF);
    wait_pe(0);
    push_win("duty_max", 10 * PD, 4'h1, 4'h1, 0);
    drain(200);
    wr(5'd2, 8'd0);
    wait_pe(0);
    push_win("per_zero", 15 * PD, 4'h1, 4'h0, 1);
    drain(200);
    wr(5'd2, 8'd10);
    push_per(0, 1, 0, 0);
    push_per(0, 0, 10 * PD, 10 * PD);
    drain(600);

    // four channels, per 4..7, duty 2
    wr(5'd0, 8'd2); wr(5'd1, 8'd0); wr(5'd2, 8'd4);
    wr(5'd4, 8'd2); wr(5'd6, 8'd5);
    wr(5'd8, 8'd2); wr(5'd10, 8'd6);
    wr(5'd12, 8'd2); wr(5'd14, 8'd7);
    wr(5'd16, 8'h0F);
    repeat (100) @(posedge sysclk);
    #1;
    for (int c = 0; c < N; c++) begin
      push_per(c, 1, 0, 0);
      push_per(c, 0, 2 * PD, (4 + c) * PD);
      push_per(c, 0, 2 * PD, (4 + c) * PD);
      push_per(c, 0, 2 * PD, (4 + c) * PD);
    end
    drain(2000);

    // disable ch2 only
    wr(5'd16, 8'h0B);
    @(posedge sysclk); #1;
    push_win("ch2_off", 15 * PD, 4'h4, 4'h0, 1);
    for (int c = 0; c < N; c++) begin
      if (c != 2) begin
        push_per(c, 1, 0, 0);
        push_per(c, 0, 2 * PD, (4 + c) * PD);
        push_per(c, 0, 2 * PD, (4 + c) * PD);
      end
    end
    drain(2000);

    // reset mid-period
    repeat (7) @(posedge sysclk);
    #1 i_rst = 1;
    @(posedge sysclk);
    #1 i_rst = 0;
    push_win("rst_mid", 10 * PD, 4'hF, 4'h0, 1);
    drain(200);

`ifdef PWM_MEM_READBACK_EN
    for (int a = 0; a <= 16; a++) rd(5'(a), 8'h00);
    wr(5'd1, 8'hA5);
    rd(5'd1, 8'hA5);
    rd(5'd31, 8'h00);
    wr(5'd16, 8'hFF);
    rd(5'd16, 8'h0F);
    repeat (3) @(posedge sysclk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
